multi_dataflow_engine_adapter: RTL and testbench
================================================

# multi_dataflow_engine_adapter

Stream adapter between the multi_dataflow streamer and the dataflow kernel, the datapath stage downstream of the control block's engine outputs. It forwards the three input streams to the kernel only while a job is running. It captures kernel output beats in a 2-entry elastic buffer, counts them against the programmed beat limit, and marks the last beat. It reports busy/done back to the controller FSM and latches the custom kernel configuration (simple_mul, shift, len) at job start.

## Interface
Parameters:
- DATA_WIDTH, 32, width of every stream data bus
- CNT_WIDTH, 32, width of beat counters and cnt_limit_i

Ports:
- clk_i  in  1  clock; everything is rising-edge
- rst_ni  in  1  synchronous, active-low reset
- clear_i  in  1  synchronous soft clear (controller clear_o)
- start_i  in  1  job start pulse from controller FSM
- cnt_limit_i  in  CNT_WIDTH  number of output beats in the job; the controller already applies +1
- reg_simple_mul_i / reg_shift_i / reg_len_i  in  32 each  custom kernel config
- kernel_simple_mul_o / kernel_shift_o / kernel_len_o  out  32 each  latched config to the kernel
- inK_data_i, inK_valid_i (K=0..2)  in  DATA_WIDTH / 1  streamer source streams
- inK_ready_o  out  1  per stream
- kernel_inK_data_o, kernel_inK_valid_o  out  DATA_WIDTH / 1  to kernel
- kernel_inK_ready_i  in  1  from kernel
- kernel_out0_data_i, kernel_out0_valid_i  in  DATA_WIDTH / 1  kernel result stream
- kernel_out0_ready_o  out  1
- out0_data_o, out0_valid_o, out0_last_o  out  DATA_WIDTH / 1 / 1  to streamer sink
- out0_ready_i  in  1
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle job completion pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE. State, counters, FIFO and config regs are registers.
- IDLE, start_i=1, cnt_limit_i≠0: go to RUN. Latch cnt_limit_i and the three reg_* inputs. Zero in_cnt and out_cnt.
- IDLE, start_i=1, cnt_limit_i=0: go directly to DONE; no beats are transferred.
- start_i outside IDLE is ignored.
- RUN:
  - kernel_inK_valid_o = inK_valid_i.
  - inK_ready_o = kernel_inK_ready_i.
  - kernel_inK_data_o = inK_data_i (combinational pass-through).
  - kernel_out0_ready_o = fifo_count<2.
  - Each kernel handshake pushes into the FIFO and increments in_cnt.
  - When the push makes in_cnt equal the limit, go to DRAIN.
- Outside RUN: all inK_ready_o, kernel_inK_valid_o and kernel_out0_ready_o are 0. Excess kernel beats stall.
- Data buses pass through unconditionally; only valid/ready are gated.
- FIFO: 2 entries, in-order.
  - out0_valid_o = fifo_count≠0; out0_data_o is the head entry.
  - A pop occurs on out0_valid_o & out0_ready_i and increments out_cnt.
  - Simultaneous push and pop at count 1 leaves the count at 1.
  - Push at count 2 is impossible, because ready is deasserted.
- out0_last_o = out0_valid_o & (out_cnt == limit−1).
- DRAIN → DONE on the cycle the final beat pops (FIFO becomes empty).
- DONE → IDLE unconditionally after one cycle.
- done_o = (state==DONE). busy_o = (state≠IDLE).
- Counters are CNT_WIDTH unsigned and never wrap within a job; the limit is at most 2^CNT_WIDTH−1.
- clear_i (any state): next cycle the block is in IDLE with FIFO empty and counters zero. Config regs are cleared to 0. No done_o pulse is generated. clear_i has priority over start_i.
- rst_ni=0: same effect as clear_i.

## Timing
- Reset values: all outputs 0, including kernel_*_o config, busy_o, done_o and out0_last_o. State is IDLE.
- start_i at cycle t: RUN and busy_o=1 at t+1. Latched config is visible on kernel_*_o at t+1.
- Kernel beat accepted at cycle t: visible on out0_valid_o at t+1 (1-cycle latency). Throughput is 1 beat/cycle while out0_ready_i=1.
- kernel_out0_ready_o depends only on registered state, with no combinational path from out0_ready_i.
- Input-side paths inK ↔ kernel_inK are combinational, gated by registered state.
- Final beat popped at cycle t: DONE at t+1, so done_o=1 at t+1 only. IDLE at t+2; a new start_i is accepted from t+2.
- Limit 0 with start at t: done_o=1 at t+1.
- out0_valid_o and out0_data_o are stable while out0_valid_o=1 and out0_ready_i=0.

## Test plan
- Reset: hold rst_ni=0 for 2 cycles with all valids=1. Expect every ready/valid=0, busy_o=0, done_o=0, kernel_*_o=0.
- Nominal run: limit=4, sink always ready, kernel sends 0x11,0x22,0x33,0x44 back-to-back, then offers 0x55.
  - Out0 beats appear one cycle after each kernel beat.
  - out0_last_o is set on 0x44 only.
  - 0x55 is never accepted (kernel_out0_ready_o=0).
  - done_o pulses the cycle after the 0x44 pop.
- Backpressure: limit=6, out0_ready_i=0 for cycles 2–5 of the run. FIFO fills to 2 and kernel_out0_ready_o drops. Expect all 6 beats in order, no loss or duplication, last on beat 6.
- Zero limit: start with cnt_limit_i=0. Expect done_o at t+1, busy_o for one cycle, no handshakes on any stream.
- Clear mid-run: limit=8, assert clear_i after 2 beats with 1 beat buffered. Next cycle expect IDLE, out0_valid_o=0, no done_o. A fresh start with limit=3 then completes with 3 beats and a correct last flag.
- Start during run and config latching:
  - Start with reg_shift_i=5.
  - During RUN, change reg_shift_i to 9 and pulse start_i.
  - Expect kernel_shift_o to stay 5, the job to be unaffected, and only one done_o pulse.

Source files
------------

// File: rtl/multi_dataflow_engine_adapter_if.sv
// Stream, configuration and status bundle between the multi_dataflow streamer/controller
// and the engine adapter. The slave modport is the adapter's view.
interface multi_dataflow_engine_adapter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  clear_i;
    logic                  start_i;
    logic [CNT_WIDTH-1:0]  cnt_limit_i;
    logic [31:0]           reg_simple_mul_i;
    logic [31:0]           reg_shift_i;
    logic [31:0]           reg_len_i;
    logic [31:0]           kernel_simple_mul_o;
    logic [31:0]           kernel_shift_o;
    logic [31:0]           kernel_len_o;

    logic [DATA_WIDTH-1:0] in0_data_i, in1_data_i, in2_data_i;
    logic                  in0_valid_i, in1_valid_i, in2_valid_i;
    logic                  in0_ready_o, in1_ready_o, in2_ready_o;
    logic [DATA_WIDTH-1:0] kernel_in0_data_o, kernel_in1_data_o, kernel_in2_data_o;
    logic                  kernel_in0_valid_o, kernel_in1_valid_o, kernel_in2_valid_o;
    logic                  kernel_in0_ready_i, kernel_in1_ready_i, kernel_in2_ready_i;

    logic [DATA_WIDTH-1:0] kernel_out0_data_i;
    logic                  kernel_out0_valid_i;
    logic                  kernel_out0_ready_o;
    logic [DATA_WIDTH-1:0] out0_data_o;
    logic                  out0_valid_o;
    logic                  out0_last_o;
    logic                  out0_ready_i;

    logic                  busy_o;
    logic                  done_o;

    modport slave (
        input  clear_i, start_i, cnt_limit_i,
        input  reg_simple_mul_i, reg_shift_i, reg_len_i,
        output kernel_simple_mul_o, kernel_shift_o, kernel_len_o,
        input  in0_data_i, in1_data_i, in2_data_i,
        input  in0_valid_i, in1_valid_i, in2_valid_i,
        output in0_ready_o, in1_ready_o, in2_ready_o,
        output kernel_in0_data_o, kernel_in1_data_o, kernel_in2_data_o,
        output kernel_in0_valid_o, kernel_in1_valid_o, kernel_in2_valid_o,
        input  kernel_in0_ready_i, kernel_in1_ready_i, kernel_in2_ready_i,
        input  kernel_out0_data_i, kernel_out0_valid_i,
        output kernel_out0_ready_o,
        output out0_data_o, out0_valid_o, out0_last_o,
        input  out0_ready_i,
        output busy_o, done_o
    );

    modport master (
        output clear_i, start_i, cnt_limit_i,
        output reg_simple_mul_i, reg_shift_i, reg_len_i,
        input  kernel_simple_mul_o, kernel_shift_o, kernel_len_o,
        output in0_data_i, in1_data_i, in2_data_i,
        output in0_valid_i, in1_valid_i, in2_valid_i,
        input  in0_ready_o, in1_ready_o, in2_ready_o,
        input  kernel_in0_data_o, kernel_in1_data_o, kernel_in2_data_o,
        input  kernel_in0_valid_o, kernel_in1_valid_o, kernel_in2_valid_o,
        output kernel_in0_ready_i, kernel_in1_ready_i, kernel_in2_ready_i,
        output kernel_out0_data_i, kernel_out0_valid_i,
        input  kernel_out0_ready_o,
        input  out0_data_o, out0_valid_o, out0_last_o,
        output out0_ready_i,
        input  busy_o, done_o
    );
endinterface

// File: rtl/multi_dataflow_engine_adapter.sv
// Gates streamer<->kernel traffic to the running job, buffers kernel results in a
// 2-entry elastic FIFO, counts beats against the job limit and flags the last one.
module multi_dataflow_engine_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input logic                          clk_i,
    input logic                          rst_ni,
    multi_dataflow_engine_adapter_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [CNT_WIDTH-1:0]  r_limit;
    logic [CNT_WIDTH-1:0]  r_in_cnt;
    logic [CNT_WIDTH-1:0]  r_out_cnt;
    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic [31:0]           r_simple_mul;
    logic [31:0]           r_shift;
    logic [31:0]           r_len;

    logic w_run;
    logic w_k_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    assign w_run       = (r_state == S_RUN);
    // Ready comes from registers only, so the sink's ready never reaches the kernel combinationally.
    assign w_k_ready   = w_run && (r_count != 2'd2);
    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = bus.kernel_out0_valid_i && w_k_ready;
    assign w_pop       = w_out_valid && bus.out0_ready_i;

    assign bus.kernel_in0_data_o  = bus.in0_data_i;
    assign bus.kernel_in1_data_o  = bus.in1_data_i;
    assign bus.kernel_in2_data_o  = bus.in2_data_i;
    assign bus.kernel_in0_valid_o = w_run && bus.in0_valid_i;
    assign bus.kernel_in1_valid_o = w_run && bus.in1_valid_i;
    assign bus.kernel_in2_valid_o = w_run && bus.in2_valid_i;
    assign bus.in0_ready_o        = w_run && bus.kernel_in0_ready_i;
    assign bus.in1_ready_o        = w_run && bus.kernel_in1_ready_i;
    assign bus.in2_ready_o        = w_run && bus.kernel_in2_ready_i;

    assign bus.kernel_out0_ready_o = w_k_ready;
    assign bus.out0_valid_o        = w_out_valid;
    assign bus.out0_data_o         = r_fifo[r_rd_ptr];
    assign bus.out0_last_o         = w_out_valid && (r_out_cnt == r_limit - CNT_WIDTH'(1));

    assign bus.kernel_simple_mul_o = r_simple_mul;
    assign bus.kernel_shift_o      = r_shift;
    assign bus.kernel_len_o        = r_len;
    assign bus.busy_o              = r_busy;
    assign bus.done_o              = r_done;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.kernel_out0_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.clear_i) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_limit      <= '0;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_simple_mul <= '0;
            r_shift      <= '0;
            r_len        <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
                r_in_cnt <= r_in_cnt + CNT_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= ~r_rd_ptr;
                r_out_cnt <= r_out_cnt + CNT_WIDTH'(1);
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            r_done  <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_busy <= 1'b1;
                        if (bus.cnt_limit_i == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= S_RUN;
                            r_limit      <= bus.cnt_limit_i;
                            r_in_cnt     <= '0;
                            r_out_cnt    <= '0;
                            r_simple_mul <= bus.reg_simple_mul_i;
                            r_shift      <= bus.reg_shift_i;
                            r_len        <= bus.reg_len_i;
                        end
                    end
                end
                S_RUN: begin
                    if (w_push && (r_in_cnt + CNT_WIDTH'(1) == r_limit)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // No pushes happen here, so popping the only entry empties the FIFO.
                    if (w_pop && (r_count == 2'd1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_dataflow_engine_adapter.sv
// Randomized bench for multi_dataflow_engine_adapter with a queue-based job model.
module tb_multi_dataflow_engine_adapter;

    localparam int DW = 32;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_dataflow_engine_adapter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus();

    multi_dataflow_engine_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Job model: a job is a limit, a queue of buffered kernel beats and two beat tallies.
    bit          m_known = 1'b0;
    bit          m_running = 1'b0;
    bit          m_done_now = 1'b0;
    int unsigned m_limit = 0;
    int unsigned m_acc = 0;
    int unsigned m_popped = 0;
    logic [31:0] m_q[$];
    logic [31:0] m_mul = '0, m_shift = '0, m_len = '0;
    int          n_done_seen = 0;

    logic [31:0] g_limit = '0, g_mul = '0, g_shift = '0, g_len = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic st, input logic cl, input logic rn, input logic kv,
                        input logic [31:0] kd, input logic ordy);
        logic        phase_run, exp_kready, exp_valid, push, pop, was_idle, nd;
        logic [31:0] d0, d1, d2;
        logic        v0, v1, v2, r0, r1, r2;
        @(negedge clk);
        d0 = $urandom; d1 = $urandom; d2 = $urandom;
        v0 = rn ? 1'($urandom_range(0, 1)) : 1'b1;
        v1 = rn ? 1'($urandom_range(0, 1)) : 1'b1;
        v2 = rn ? 1'($urandom_range(0, 1)) : 1'b1;
        r0 = 1'($urandom_range(0, 1));
        r1 = 1'($urandom_range(0, 1));
        r2 = 1'($urandom_range(0, 1));
        rst_n                   = rn;
        bus.clear_i             = cl;
        bus.start_i             = st;
        bus.cnt_limit_i         = g_limit;
        bus.reg_simple_mul_i    = g_mul;
        bus.reg_shift_i         = g_shift;
        bus.reg_len_i           = g_len;
        bus.in0_data_i = d0; bus.in1_data_i = d1; bus.in2_data_i = d2;
        bus.in0_valid_i = v0; bus.in1_valid_i = v1; bus.in2_valid_i = v2;
        bus.kernel_in0_ready_i = r0; bus.kernel_in1_ready_i = r1; bus.kernel_in2_ready_i = r2;
        bus.kernel_out0_valid_i = kv;
        bus.kernel_out0_data_i  = kd;
        bus.out0_ready_i        = ordy;
        #1;
        phase_run  = m_running && (m_acc < m_limit);
        exp_kready = phase_run && (m_q.size() < 2);
        exp_valid  = (m_q.size() != 0);
        if (m_known) begin
            chk("busy", bus.busy_o, m_running || m_done_now);
            chk("done", bus.done_o, m_done_now);
            chk("k_out_rdy", bus.kernel_out0_ready_o, exp_kready);
            chk("out_vld", bus.out0_valid_o, exp_valid);
            if (exp_valid) begin
                chk("out_data", bus.out0_data_o, m_q[0]);
                chk("out_last", bus.out0_last_o, m_popped == m_limit - 1);
            end else begin
                chk("out_last", bus.out0_last_o, 0);
            end
            chk("in0_rdy", bus.in0_ready_o, phase_run && r0);
            chk("in1_rdy", bus.in1_ready_o, phase_run && r1);
            chk("in2_rdy", bus.in2_ready_o, phase_run && r2);
            chk("k_in0_vld", bus.kernel_in0_valid_o, phase_run && v0);
            chk("k_in1_vld", bus.kernel_in1_valid_o, phase_run && v1);
            chk("k_in2_vld", bus.kernel_in2_valid_o, phase_run && v2);
            chk("k_in0_data", bus.kernel_in0_data_o, d0);
            chk("k_in1_data", bus.kernel_in1_data_o, d1);
            chk("k_in2_data", bus.kernel_in2_data_o, d2);
            chk("cfg_mul", bus.kernel_simple_mul_o, m_mul);
            chk("cfg_shift", bus.kernel_shift_o, m_shift);
            chk("cfg_len", bus.kernel_len_o, m_len);
            if (bus.done_o === 1'b1) n_done_seen++;
        end
        push     = kv && exp_kready;
        pop      = exp_valid && ordy;
        was_idle = !m_running && !m_done_now;
        @(posedge clk);
        if (!rn || cl) begin
            if (!rn) m_known = 1'b1;
            m_running = 1'b0; m_done_now = 1'b0;
            m_acc = 0; m_popped = 0; m_limit = 0;
            m_q.delete();
            m_mul = '0; m_shift = '0; m_len = '0;
        end else begin
            nd = 1'b0;
            if (pop) begin
                void'(m_q.pop_front());
                m_popped++;
                if (m_popped == m_limit) begin
                    m_running = 1'b0;
                    nd = 1'b1;
                end
            end
            if (push) begin
                m_q.push_back(kd);
                m_acc++;
            end
            if (st && was_idle) begin
                if (g_limit == 0) begin
                    nd = 1'b1;
                end else begin
                    m_running = 1'b1;
                    m_limit = g_limit; m_acc = 0; m_popped = 0;
                    m_mul = g_mul; m_shift = g_shift; m_len = g_len;
                end
            end
            m_done_now = nd;
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((m_running || m_done_now) && n < max) begin
            step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
            n++;
        end
        chk("drain_timeout", m_running || m_done_now, 0);
    endtask

    initial begin
        bus.clear_i = 1'b0; bus.start_i = 1'b0; bus.cnt_limit_i = '0;
        bus.reg_simple_mul_i = '0; bus.reg_shift_i = '0; bus.reg_len_i = '0;
        bus.in0_data_i = '0; bus.in1_data_i = '0; bus.in2_data_i = '0;
        bus.in0_valid_i = 1'b0; bus.in1_valid_i = 1'b0; bus.in2_valid_i = 1'b0;
        bus.kernel_in0_ready_i = 1'b0; bus.kernel_in1_ready_i = 1'b0; bus.kernel_in2_ready_i = 1'b0;
        bus.kernel_out0_data_i = '0; bus.kernel_out0_valid_i = 1'b0; bus.out0_ready_i = 1'b0;

        // Reset with every valid asserted
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        // Nominal run: limit 4, back-to-back beats, then an excess beat that must stall
        g_limit = 4; g_mul = 32'h3; g_shift = 32'h2; g_len = 32'h10;
        n_done_seen = 0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'h11 * i, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 1'b1);
        drain(50);
        chk("nominal_done_cnt", n_done_seen, 1);

        // Backpressure: limit 6, sink stalls on run cycles 2..5
        g_limit = 6;
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 1; i <= 14; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, $urandom, !(i >= 2 && i <= 5));
        drain(50);

        // Zero limit: immediate completion
        g_limit = 0;
        n_done_seen = 0;
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h77, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h77, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h77, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h77, 1'b1);
        chk("zero_done_cnt", n_done_seen, 1);

        // Clear mid-run with one beat buffered, then a fresh limit-3 job
        g_limit = 8;
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hA1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hA2, 1'b1);
        n_done_seen = 0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hA3, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hA4, 1'b1);
        chk("clear_no_done", n_done_seen, 0);
        g_limit = 3;
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        drain(60);

        // Start during run must not relatch config or restart the job
        g_limit = 5; g_shift = 5;
        n_done_seen = 0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, $urandom, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, $urandom, 1'b1);
        g_shift = 9;
        step(1'b1, 1'b0, 1'b1, 1'b1, $urandom, 1'b1);
        #1;
        chk("cfg_shift_hold", bus.kernel_shift_o, 5);
        drain(60);
        chk("restart_done_cnt", n_done_seen, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            g_limit = $urandom_range(0, 7);
            g_mul = $urandom; g_shift = $urandom; g_len = $urandom;
            step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 149) == 0),
                 1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 2) != 0),
                 $urandom, 1'($urandom_range(0, 3) != 0));
        end
        drain(60);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
